// File: rtl/spi_controller.sv
// SPI mode-0 initiator: one parallel command becomes one 16-bit frame {rw, addr[6:0], data[7:0]}.
// Define SPI_CTRL_ADDR_CHECK_EN to reject addresses above MAX_ADDR without issuing a frame.
module spi_controller #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned GAP_CYC   = 4,
  parameter int unsigned MAX_ADDR  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  output logic       sclk,
  output logic       cs_n,
  output logic       copi,
  input  logic       cipo
);

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] CntOne = CntW'(1);

`ifdef SPI_CTRL_ADDR_CHECK_EN
  localparam bit AddrCheck = 1'b1;
`else
  localparam bit AddrCheck = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [3:0]        bit_q;
  logic [15:0]       shreg_q;
  logic              rw_q;
  logic [7:0]        rx_q;
  logic              sclk_q;
  logic              cs_n_q;
  logic              copi_q;
  logic              rsp_valid_q;
  logic [7:0]        rsp_rdata_q;
  logic              rsp_err_q;
  logic              addr_reject;

  assign addr_reject = AddrCheck && ({25'd0, cmd_addr} > MAX_ADDR);

  assign cmd_ready = (state_q == StIdle);
  assign busy      = !cmd_ready;
  assign sclk      = sclk_q;
  assign cs_n      = cs_n_q;
  assign copi      = copi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      rw_q        <= 1'b0;
      rx_q        <= '0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      copi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (addr_reject) begin
              // Reuse GAP's exit path so the rejection lasts exactly one cycle.
              state_q     <= StGap;
              cnt_q       <= CntW'(GAP_CYC - 1);
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q <= StSetup;
              cnt_q   <= '0;
              cs_n_q  <= 1'b0;
              copi_q  <= cmd_write;
              rw_q    <= cmd_write;
              shreg_q <= {cmd_write, cmd_addr, (cmd_write ? cmd_wdata : 8'h00)};
            end
          end
        end
        StSetup: begin
          if (cnt_q == CntW'(SETUP_CYC - 1)) begin
            state_q <= StShift;
            cnt_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b1;
            rx_q    <= {rx_q[6:0], cipo};
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StShift: begin
          if (cnt_q == CntW'(CLK_DIV - 1)) begin
            cnt_q <= '0;
            if (sclk_q) begin
              sclk_q <= 1'b0;
              // The 16th fall counts as the first HOLD cycle; copi keeps bit 0.
              if (bit_q == 4'd15) begin
                state_q <= StHold;
              end else begin
                bit_q   <= bit_q + 4'd1;
                shreg_q <= {shreg_q[14:0], 1'b0};
                copi_q  <= shreg_q[14];
              end
            end else begin
              sclk_q <= 1'b1;
              rx_q   <= {rx_q[6:0], cipo};
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StHold: begin
          if (cnt_q == CntW'(HOLD_CYC - 1)) begin
            state_q     <= StGap;
            cnt_q       <= '0;
            cs_n_q      <= 1'b1;
            copi_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            if (!rw_q) begin
              rsp_rdata_q <= rx_q;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StGap: begin
          if (cnt_q == CntW'(GAP_CYC - 1)) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
